// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared widths, sequencer state encoding and the 8-bit saturator
package fc_pkg;

    localparam int DATA_W = 8;
    localparam int PROD_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        BIAS  = 3'd3,
        OUT   = 3'd4
    } fc_mac_state_t;

    function automatic logic signed [DATA_W-1:0] sat8(input logic signed [63:0] v);
        if (v > 64'sd127)
            return 8'sd127;
        else if (v < -64'sd128)
            return -8'sd128;
        else
            return v[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/fc_out_stage.sv
// rtl/fc_out_stage.sv - combinational floor shift, saturate to int8 and optional ReLU
module fc_out_stage
    import fc_pkg::*;
#(
    parameter int ACC_W     = 24,
    parameter int OUT_SHIFT = 6
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic                     relu_en,
    output logic signed [DATA_W-1:0] result
);

    logic signed [ACC_W-1:0] s;
    logic signed [63:0]      s_ext;

    // Arithmetic shift of a signed value rounds toward minus infinity.
    assign s      = acc >>> OUT_SHIFT;
    assign s_ext  = 64'(s);
    assign result = (relu_en && s[ACC_W-1]) ? '0 : sat8(s_ext);

endmodule

// File: rtl/fc_mac_seq.sv
// rtl/fc_mac_seq.sv - one fully connected neuron: walk node/weight RAMs, MAC, bias, rescale
module fc_mac_seq
    import fc_pkg::*;
#(
    parameter  int N_IN      = 16,
    parameter  int ACC_W     = 24,
    parameter  int OUT_SHIFT = 6,
    localparam int AW        = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     relu_en,
    input  logic signed [DATA_W-1:0] bias,
    output logic                     mem_en,
    output logic [AW-1:0]            mem_addr,
    input  logic signed [DATA_W-1:0] node,
    input  logic signed [DATA_W-1:0] wegt,
    output logic                     busy,
    output logic                     done,
    output logic signed [ACC_W-1:0]  acc_out,
    output logic signed [DATA_W-1:0] result
);

    localparam logic [AW-1:0] LAST = AW'(N_IN - 1);

    fc_mac_state_t state, state_nxt;

    logic [AW-1:0]            idx;
    logic                     rd_pend;
    logic                     relu_q;
    logic signed [DATA_W-1:0] bias_q;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_hold;
    logic signed [DATA_W-1:0] res_hold;
    logic signed [DATA_W-1:0] res_stage;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;

    assign prod     = PROD_W'(node) * PROD_W'(wegt);
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign bias_ext = {{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (idx == LAST) state_nxt = DRAIN;
            DRAIN:   state_nxt = BIAS;
            BIAS:    state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_en   = (state == RUN);
    assign mem_addr = mem_en ? idx : '0;
    assign busy     = (state != IDLE);
    assign done     = (state == OUT);

    // Fresh values are visible in the done cycle itself; the hold registers keep them afterwards.
    assign acc_out  = done ? acc : acc_hold;
    assign result   = done ? res_stage : res_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            rd_pend  <= 1'b0;
            relu_q   <= 1'b0;
            bias_q   <= '0;
            acc      <= '0;
            acc_hold <= '0;
            res_hold <= '0;
        end else begin
            state   <= state_nxt;
            rd_pend <= mem_en;
            case (state)
                IDLE: begin
                    if (start) begin
                        bias_q <= bias;
                        relu_q <= relu_en;
                        acc    <= '0;
                        idx    <= '0;
                    end
                end
                RUN: begin
                    idx <= idx + AW'(1);
                    if (rd_pend) acc <= acc + prod_ext;
                end
                DRAIN: begin
                    if (rd_pend) acc <= acc + prod_ext;
                end
                BIAS: begin
                    acc <= acc + bias_ext;
                end
                OUT: begin
                    acc_hold <= acc;
                    res_hold <= res_stage;
                end
                default: ;
            endcase
        end
    end

    fc_out_stage #(
        .ACC_W    (ACC_W),
        .OUT_SHIFT(OUT_SHIFT)
    ) u_out_stage (
        .acc    (acc),
        .relu_en(relu_q),
        .result (res_stage)
    );

endmodule

// File: tb/tb_fc_mac_seq.sv
// tb/tb_fc_mac_seq.sv - directed table and sequence checks for fc_mac_seq at N_IN=4 and N_IN=16
module tb_fc_mac_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start4 = 1'b0, start16 = 1'b0;
    logic relu = 1'b0;
    logic signed [7:0] bias = '0;

    logic              mem_en4, mem_en16;
    logic [1:0]        addr4;
    logic [3:0]        addr16;
    logic signed [7:0] node4 = '0, wegt4 = '0, node16 = '0, wegt16 = '0;
    logic              busy4, busy16, done4, done16;
    logic signed [23:0] acc4, acc16;
    logic signed [7:0]  res4, res16;

    logic signed [7:0] nmem [16];
    logic signed [7:0] wmem [16];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fc_mac_seq #(.N_IN(4), .ACC_W(24), .OUT_SHIFT(6)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .relu_en(relu), .bias(bias),
        .mem_en(mem_en4), .mem_addr(addr4), .node(node4), .wegt(wegt4),
        .busy(busy4), .done(done4), .acc_out(acc4), .result(res4)
    );

    fc_mac_seq #(.N_IN(16), .ACC_W(24), .OUT_SHIFT(6)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .relu_en(relu), .bias(bias),
        .mem_en(mem_en16), .mem_addr(addr16), .node(node16), .wegt(wegt16),
        .busy(busy16), .done(done16), .acc_out(acc16), .result(res16)
    );

    // One-cycle-latency synchronous RAM models.
    always @(posedge clk) begin
        if (mem_en4) begin
            node4 <= nmem[{2'b00, addr4}];
            wegt4 <= wmem[{2'b00, addr4}];
        end
        if (mem_en16) begin
            node16 <= nmem[addr16];
            wegt16 <= wmem[addr16];
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] pk4(input int a0, input int a1, input int a2, input int a3);
        return {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    endfunction

    task automatic load4(input logic [31:0] n, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            nmem[i] = n[8*i +: 8];
            wmem[i] = w[8*i +: 8];
        end
    endtask

    task automatic run_op(input int sel, input logic signed [7:0] b, input logic r,
                          input int e_acc, input int e_res, input string nm);
        int n;
        int got_done;
        int nadr;
        int addr_ok;
        logic m_en, dn, bz;
        int ad;
        n = (sel != 0) ? 16 : 4;
        got_done = -1;
        nadr = 0;
        addr_ok = 1;
        @(negedge clk);
        bias = b;
        relu = r;
        if (sel != 0) start16 = 1'b1; else start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        start16 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            m_en = (sel != 0) ? mem_en16 : mem_en4;
            dn   = (sel != 0) ? done16 : done4;
            bz   = (sel != 0) ? busy16 : busy4;
            ad   = (sel != 0) ? int'(addr16) : int'(addr4);
            if (m_en) begin
                if (ad != nadr) addr_ok = 0;
                nadr++;
            end
            if (k == 1) chk({nm, " busy_start"}, bz, 1);
            if (dn) begin
                got_done = k;
                chk({nm, " acc_out"}, (sel != 0) ? acc16 : acc4, e_acc);
                chk({nm, " result"}, (sel != 0) ? res16 : res4, e_res);
                chk({nm, " busy_at_done"}, bz, 1);
                break;
            end
        end
        chk({nm, " done_latency"}, got_done, n + 3);
        chk({nm, " addr_count"}, nadr, n);
        chk({nm, " addr_order"}, addr_ok, 1);
        @(negedge clk);
        chk({nm, " busy_after"}, (sel != 0) ? busy16 : busy4, 0);
        chk({nm, " done_after"}, (sel != 0) ? done16 : done4, 0);
        chk({nm, " result_held"}, (sel != 0) ? res16 : res4, e_res);
    endtask

    typedef struct {
        logic [31:0]       nodes;
        logic [31:0]       wegts;
        logic signed [7:0] b;
        logic              r;
        int                e_acc;
        int                e_res;
        string             nm;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int dk [$];
        int nadr;
        int addr_ok;
        int k_hit;

        tbl[0] = '{pk4(-50, -50, -50, -50), pk4(-50, -50, -50, -50), 8'sd0,    1'b0, 10000,  127,  "pos_sat"};
        tbl[1] = '{pk4(50, 50, 50, 50),     pk4(-50, -50, -50, -50), 8'sd0,    1'b0, -10000, -128, "neg_sat"};
        tbl[2] = '{pk4(50, 50, 50, 50),     pk4(-50, -50, -50, -50), 8'sd0,    1'b1, -10000, 0,    "neg_relu"};
        tbl[3] = '{pk4(1, 1, 1, 1),         pk4(1, 1, 1, 1),         -8'sd101, 1'b0, -97,    -2,   "floor_bias"};
        tbl[4] = '{pk4(1, 2, 3, 4),         pk4(10, -20, 30, -40),   8'sd5,    1'b0, -95,    -2,   "ramp"};
        tbl[5] = '{pk4(1, 2, 3, 4),         pk4(10, -20, 30, -40),   8'sd5,    1'b1, -95,    0,    "ramp_relu"};
        tbl[6] = '{pk4(100, 100, 100, 100), pk4(1, 1, 1, 1),         8'sd63,   1'b1, 463,    7,    "pos_relu"};

        for (int i = 0; i < 16; i++) begin
            nmem[i] = '0;
            wmem[i] = '0;
        end

        // Reset state
        #12;
        chk("rst mem_en", mem_en4, 0);
        chk("rst mem_addr", addr4, 0);
        chk("rst busy", busy4, 0);
        chk("rst done", done4, 0);
        chk("rst acc_out", acc4, 0);
        chk("rst result", res4, 0);
        chk("rst busy16", busy16, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            load4(tbl[i].nodes, tbl[i].wegts);
            run_op(0, tbl[i].b, tbl[i].r, tbl[i].e_acc, tbl[i].e_res, tbl[i].nm);
        end

        // Widest case: full 16 pairs must not wrap the 24-bit accumulator.
        for (int i = 0; i < 16; i++) begin
            nmem[i] = 8'sd127;
            wmem[i] = -8'sd128;
        end
        run_op(1, -8'sd128, 1'b0, -260224, -128, "n16_max");

        // start held high across a whole operation.
        load4(pk4(1, 1, 1, 1), pk4(1, 1, 1, 1));
        nadr = 0;
        addr_ok = 1;
        @(negedge clk);
        bias = -8'sd101;
        relu = 1'b0;
        start4 = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (mem_en4) begin
                if (int'(addr4) != (nadr % 4)) addr_ok = 0;
                nadr++;
            end
            if (done4) begin
                dk.push_back(k);
                chk("held acc_out", acc4, -97);
            end
            if (k == 8) chk("held busy_gap", busy4, 0);
            if (k == 15) start4 = 1'b0;
        end
        chk("held done_count", dk.size(), 2);
        chk("held done1", (dk.size() > 0) ? dk[0] : -1, 7);
        chk("held done2", (dk.size() > 1) ? dk[1] : -1, 15);
        chk("held addr_count", nadr, 8);
        chk("held addr_order", addr_ok, 1);
        @(negedge clk);
        chk("held idle_after", busy4, 0);

        // Reset in RUN while address 2 is presented.
        load4(pk4(-50, -50, -50, -50), pk4(-50, -50, -50, -50));
        k_hit = -1;
        @(negedge clk);
        bias = 8'sd0;
        relu = 1'b0;
        start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (mem_en4 && addr4 == 2'd2) begin
                k_hit = k;
                break;
            end
        end
        chk("mrst addr2_cycle", k_hit, 3);
        #1;
        rst = 1'b1;
        #1;
        chk("mrst mem_en", mem_en4, 0);
        chk("mrst mem_addr", addr4, 0);
        chk("mrst busy", busy4, 0);
        chk("mrst done", done4, 0);
        chk("mrst acc_out", acc4, 0);
        chk("mrst result", res4, 0);
        @(negedge clk);
        chk("mrst no_done", done4, 0);
        rst = 1'b0;
        run_op(0, 8'sd0, 1'b0, 10000, 127, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fc_mac_seq.md
# fc_mac_seq

Sequencer for one fully connected neuron. On `start` it walks `N_IN` node/weight pairs out of external synchronous memories, multiplies each pair as signed 8×8 into a 16-bit product, and accumulates the products into a wide accumulator. It then adds the neuron bias, rescales, saturates, applies an optional ReLU, and presents one signed 8-bit activation with a one-cycle `done` pulse. It sits between the layer controller (which issues `start`) and the node/weight RAMs.

## Interface
- `N_IN`, 16: pairs per neuron (≥1).
- `ACC_W`, 24: accumulator width; must be ≥ 16 + clog2(N_IN) + 1.
- `OUT_SHIFT`, 6: arithmetic right shift applied before saturation.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a neuron; sampled only in IDLE.
- `relu_en` in 1: clamp negative results to 0; sampled with `start`.
- `bias` in 8 signed: neuron bias; sampled with `start`.
- `mem_en` out 1: read strobe to node/weight RAMs.
- `mem_addr` out clog2(N_IN): pair index.
- `node` in 8 signed: node read data, valid the cycle after `mem_en`.
- `wegt` in 8 signed: weight read data, valid the cycle after `mem_en`.
- `busy` out 1: high from the cycle after `start` is accepted until `done`, inclusive.
- `done` out 1: one-cycle pulse; `result` is valid from this cycle on.
- `acc_out` out ACC_W signed: final accumulator value after bias, held until the next `done`.
- `result` out 8 signed: final activation, held until the next `done`.

## Operation
- States: IDLE, RUN, DRAIN, BIAS, OUT.
- IDLE:
  - On `start`, latch `bias` and `relu_en`, clear the accumulator and the index, and go to RUN.
  - When not in IDLE, `start` is ignored.
- RUN:
  - Each cycle drive `mem_en=1` and `mem_addr=idx`, then increment `idx`.
  - Each cycle, if the read issued in the previous cycle is pending, add `node*wegt` (signed 16-bit, sign-extended to ACC_W) to the accumulator.
  - After issuing `idx=N_IN-1`, go to DRAIN.
- DRAIN: `mem_en=0`; accumulate the last product; go to BIAS.
- BIAS: `acc += sign_extend(bias)`, unshifted; go to OUT.
- OUT:
  - `acc_out ← acc`.
  - `s = acc >>> OUT_SHIFT`, rounding toward −∞.
  - `result ← sat8(s)`, clamped to [−128, 127]; if `relu_en` and `s < 0`, `result ← 0`.
  - Pulse `done`; go to IDLE.
- The accumulator never wraps when ACC_W meets the parameter rule.
- Reset mid-operation: return to IDLE immediately. No `done` is produced and the partial accumulation is discarded.
- `start` asserted in the same cycle as `done`: ignored, because the state is not IDLE. The next `start` is accepted one cycle later.

## Timing
- Reset values: `mem_en=0`, `mem_addr=0`, `busy=0`, `done=0`, `acc_out=0`, `result=0`; state IDLE.
- Clock edge E0 accepts `start`. `mem_en` is high for exactly N_IN cycles, with the addresses 0..N_IN−1 presented in order starting in the cycle after E0.
- `done` is high in cycle N_IN+3 after E0. Total latency is N_IN+3 cycles; back-to-back throughput is one neuron per N_IN+4 cycles.
- RAM read latency is exactly 1 cycle. A different latency is not supported.
- `busy` deasserts in the cycle after `done`.

## Structure
- Shared package `fc_pkg` holds:
  - `DATA_W=8` and `PROD_W=16`
  - the state enum `fc_mac_state_t` {IDLE, RUN, DRAIN, BIAS, OUT}
  - the `sat8` function
- Sub-module `fc_out_stage`: combinational shift, saturate and ReLU, parameterised by ACC_W and OUT_SHIFT. It is reused by later layer blocks.
- The multiply is inline: one signed 8×8 product per cycle, feeding the accumulator adder.

## Test plan
- N_IN=4, all node=−50, wegt=−50, bias=0, relu off → `acc_out`=10000, `result`=127 (saturated; the shifted value is 156), `done` at E0+7.
- N_IN=4, node=50, wegt=−50, bias=0 → `acc_out`=−10000, `result`=−128. Repeat with relu_en=1 → `result`=0.
- N_IN=4, node=1, wegt=1, bias=−101 → `acc_out`=−97, `result`=−2 (floor of the shift).
- `start` held high through an entire operation → exactly one `done`; the second operation begins only after the cycle following `done`; the `mem_addr` sequence is 0,1,2,3 each time.
- `rst` asserted in RUN while `mem_addr`=2 → all outputs return to their reset values within the same cycle, with no `done`; a fresh `start` then yields the correct result.
- N_IN=16, all node=127, wegt=−128, bias=−128 → `acc_out`=−260224 with no wrap at ACC_W=24, `result`=−128.
